relu_requant_stream: RTL
========================

Name: relu_requant_stream

Overview:
- Downstream stage of the matrix-vector multiplier.
- Captures one full accumulator result vector plus a bias vector in a single valid/ready transfer.
- Serially adds bias, applies ReLU and requantises each element: arithmetic shift, then unsigned saturation.
- Emits one OUT_WIDTH element per cycle on a valid/ready stream toward the next layer's input buffer.

Parameters:
- ROWS, 6, number of elements in the result vector (matrix rows).
- ACC_WIDTH, 20, signed width of each accumulator and bias element.
- OUT_WIDTH, 8, unsigned width of each output element.
- SHIFT, 4, right-shift applied after bias and ReLU; 0 is legal.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream vector and bias are valid.
- in_ready  output  1  block can accept a vector.
- in_vector  input  ROWS*ACC_WIDTH  signed accumulators; element i at bits [i*ACC_WIDTH +: ACC_WIDTH].
- in_bias  input  ROWS*ACC_WIDTH  signed biases, same packing as in_vector.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  OUT_WIDTH  requantised element.
- out_index  output  $clog2(ROWS)  index of the element in out_data.
- out_last  output  1  marks element ROWS-1.
- busy  output  1  a vector is held and not yet fully emitted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n, as already decided.
- Reset values, while reset_n is low:
  - out_valid=0, out_data=0, out_index=0, out_last=0, busy=0.
  - State is IDLE and the element counter is 0.
  - in_ready=1, driven combinationally from state==IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k, register both vectors, set counter to 0 and go to EMIT.
  - EMIT: in_ready=0 and busy=1. The output register holds element `counter`.
    - On out_valid&&out_ready with counter<ROWS-1: increment counter and load the next element in the same edge, so there are no bubbles.
    - On that handshake with counter==ROWS-1: go to IDLE and drop out_valid.
- Latency and throughput:
  - out_valid rises at edge k+1 with element 0.
  - Throughput is 1 element/cycle while out_ready=1.
  - ROWS elements take ROWS cycles. in_ready returns 1 in the cycle after the last handshake.
  - Back-to-back vectors therefore need one idle cycle.
- Element arithmetic:
  - sum = acc[i] + bias[i], computed at ACC_WIDTH+1 bits signed. No wrap.
  - If sum<0, result is 0.
  - Otherwise q = sum >>> SHIFT, truncating toward zero for non-negative values.
  - If q > 2^OUT_WIDTH-1, out_data = 2^OUT_WIDTH-1; else out_data = q.
  - The computation is registered into out_data, so output is glitch-free and stable.
- Stream rules:
  - While out_valid&&!out_ready, out_data, out_index and out_last stay constant.
  - out_valid never drops without a handshake, except on reset.
  - out_last = (out_index==ROWS-1) && out_valid.
- Boundary conditions:
  - in_valid while busy is ignored; in_ready=0 and nothing is latched. Upstream must hold its data.
  - out_ready high while out_valid=0 has no effect.
  - Input changes after capture have no effect on the vector in flight.
  - Reset mid-vector: outputs return to reset values immediately and asynchronously. The partial vector is discarded. The next accepted vector restarts at index 0.
  - ROWS=1: first output has out_last=1 and returns to IDLE after one handshake.

Test Plan (ROWS=6, ACC_WIDTH=20, OUT_WIDTH=8, SHIFT=4):
- Basic stream: in_vector={16,32,-5,0,4095,100}, bias all 0, out_ready=1 → out_data 1,2,0,0,255,6 on 6 consecutive cycles starting at edge k+1. out_index runs 0..5, out_last only on the 6th, in_ready=1 on the next cycle.
- Bias and saturation: acc={10,10,8191,-1,0,47}, bias={-20,22,0,1,-1,1} → 0,2,255,0,0,3.
- Width extremes: acc={524287,-524288,...}, bias={524287,-524288,...} → 255 and 0, with no wrap-around.
- Backpressure: hold out_ready=0 while index 2 is presented for 3 cycles → out_data, out_index and out_last are stable for those cycles. All 6 elements arrive in order with none dropped or duplicated.
- Busy rejection: assert in_valid with a second vector during EMIT → in_ready=0 and it is not captured. It is accepted in the first IDLE cycle after out_last, and its elements match the second vector.
- Reset mid-operation: pull reset_n low while index 3 is presented → out_valid=0 immediately and busy=0, then in_ready=1 after release. A new vector streams from index 0 with correct values.

Source files
------------

// File: rtl/relu_requant_stream.sv
// relu_requant_stream: captures an accumulator vector and a bias vector in one
// handshake, then streams bias-added, ReLU'd, shifted and saturated elements
// one per cycle on a valid/ready interface.
module relu_requant_stream #(
    parameter int ROWS      = 6,
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4,
    localparam int IDX_WIDTH = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*ACC_WIDTH-1:0]   in_vector,
    input  logic [ROWS*ACC_WIDTH-1:0]   in_bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [IDX_WIDTH-1:0]        out_index,
    output logic                        out_last,
    output logic                        busy
);

    localparam int SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic [SUM_WIDTH-1:0] SAT_LIMIT  = SUM_WIDTH'({OUT_WIDTH{1'b1}});
    localparam logic [IDX_WIDTH-1:0] LAST_INDEX = IDX_WIDTH'(ROWS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   counter;
    logic [IDX_WIDTH-1:0]   next_index;
    logic [ACC_WIDTH-1:0]   acc_mem  [ROWS];
    logic [ACC_WIDTH-1:0]   bias_mem [ROWS];
    logic                   capture;
    logic                   advance;

    // Bias add at one extra bit (cannot wrap), ReLU, shift, unsigned saturate.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [ACC_WIDTH-1:0] bias
    );
        logic signed [SUM_WIDTH-1:0] sum;
        logic [SUM_WIDTH-1:0]        shifted;
        logic [OUT_WIDTH-1:0]        result;
        sum     = $signed({acc[ACC_WIDTH-1], acc}) + $signed({bias[ACC_WIDTH-1], bias});
        shifted = '0;
        result  = '0;
        if (!sum[SUM_WIDTH-1]) begin
            shifted = $unsigned(sum) >> SHIFT;
            result  = (shifted > SAT_LIMIT) ? '1 : shifted[OUT_WIDTH-1:0];
        end
        return result;
    endfunction

    assign in_ready   = (state == IDLE);
    assign capture    = in_valid && (state == IDLE);
    assign advance    = out_valid && out_ready;
    assign next_index = counter + IDX_WIDTH'(1);
    assign out_index  = counter;

    // Vector storage; only written on capture, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int unsigned i = 0; i < ROWS; i++) begin
                acc_mem[i]  <= in_vector[i*ACC_WIDTH +: ACC_WIDTH];
                bias_mem[i] <= in_bias[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    // Control FSM with registered stream outputs. Element 0 is computed straight
    // from the input bus at capture; later elements come from storage, loaded on
    // the same edge as the handshake so the stream has no bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            counter   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state     <= EMIT;
                        counter   <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_data  <= requant(in_vector[ACC_WIDTH-1:0], in_bias[ACC_WIDTH-1:0]);
                        out_last  <= (ROWS == 1);
                    end
                end
                EMIT: begin
                    if (advance) begin
                        if (counter == LAST_INDEX) begin
                            state     <= IDLE;
                            counter   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            counter  <= next_index;
                            out_data <= requant(acc_mem[next_index], bias_mem[next_index]);
                            out_last <= (next_index == LAST_INDEX);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
